// File: rtl/vscale_regfile_mp.sv
// Multi-port integer register file with optional hardware-zero entry,
// same-cycle write-to-read bypass, valid-bit reset and a busy scoreboard.
module vscale_regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CW       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                bset_en,
  input  logic [AW-1:0]       bset_addr,
  output logic [CW-1:0]       busy_cnt
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0]  data [NREGS];
  logic [NREGS-1:0] valid;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] set_vec;
  logic [NWR-1:0]   wen_eff;
  logic [CW-1:0]    cnt_nxt;

  // Address targets a real, writable register
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && ((ZERO_REG == 0) || (a != '0));
  endfunction

  // Qualify writes and the busy set; build per-register hit vectors
  always_comb begin
    wen_eff = '0;
    wr_hit  = '0;
    set_vec = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      wen_eff[j] = wen[j] & rst_n & addr_ok(wa[j*AW +: AW]);
    end
    for (int r = 0; r < int'(NREGS); r++) begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (wen_eff[j] && (wa[j*AW +: AW] == AW'(r))) wr_hit[r] = 1'b1;
      end
      set_vec[r] = bset_en & rst_n & addr_ok(bset_addr) & (bset_addr == AW'(r));
    end
  end

  // Next busy vector (set beats a same-cycle clear) and its population count
  always_comb begin
    busy_nxt = (busy & ~wr_hit) | set_vec;
    cnt_nxt  = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end
  end

  // Data array: no reset, highest-index port overrides on collision
  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(NWR); j++) begin
      if (wen_eff[j]) data[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
    end
  end

  // Valid bits, busy scoreboard and busy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      valid    <= valid | wr_hit;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports with optional same-cycle forwarding
  always_comb begin
    logic [AW-1:0]   a;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      a        = ra[i*AW +: AW];
      byp_hit  = 1'b0;
      byp_data = '0;
      if (BYPASS != 0) begin
        for (int j = 0; j < int'(NWR); j++) begin
          if (wen_eff[j] && (wa[j*AW +: AW] == a)) begin
            byp_hit  = 1'b1;
            byp_data = wd[j*XLEN +: XLEN];
          end
        end
      end
      if (addr_ok(a)) begin
        if (byp_hit) begin
          rd[i*XLEN +: XLEN] = byp_data;
        end else if (valid[a]) begin
          rd[i*XLEN +: XLEN] = data[a];
        end
        rd_busy[i] = byp_hit ? 1'b0 : busy[a];
      end
    end
  end

endmodule

// File: tb/tb_vscale_regfile_mp.sv
// Bench for vscale_regfile_mp: bypass and non-bypass instances share stimulus.
module tb_vscale_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ra;
  logic [1:0]  wen;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        bset_en;
  logic [4:0]  bset_addr;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  rdb_b, rdb_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_data  [32];
  bit          m_valid [32];
  bit          m_busy  [32];

  always #5 clk = ~clk;

  vscale_regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
    .wen(wen), .wa(wa), .wd(wd), .bset_en(bset_en), .bset_addr(bset_addr),
    .busy_cnt(cnt_b));

  vscale_regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
    .wen(wen), .wa(wa), .wd(wd), .bset_en(bset_en), .bset_addr(bset_addr),
    .busy_cnt(cnt_n));

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [31:0] e_rd_b, e_rd_n;
    logic        e_bz_b, e_bz_n;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] wa_of(input int j);
    return wa[j*5 +: 5];
  endfunction

  function automatic bit eff_wr(input int j);
    return wen[j] && rst_n && (wa_of(j) != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    bit          hit = 0;
    logic [31:0] v   = 0;
    if (!rst_n || a == 5'd0) return 32'd0;
    if (byp) begin
      for (int j = 0; j < 2; j++)
        if (eff_wr(j) && wa_of(j) == a) begin hit = 1; v = wd[j*32 +: 32]; end
      if (hit) return v;
    end
    return m_valid[a] ? m_data[a] : 32'd0;
  endfunction

  function automatic bit exp_bz(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (byp)
      for (int j = 0; j < 2; j++)
        if (eff_wr(j) && wa_of(j) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Reference update at a clock edge, using the inputs the DUT sampled
  task automatic model_edge();
    bit nb [32];
    if (!rst_n) return;
    nb = m_busy;
    for (int j = 0; j < 2; j++)
      if (eff_wr(j)) begin
        m_data[wa_of(j)]  = wd[j*32 +: 32];
        m_valid[wa_of(j)] = 1;
        nb[wa_of(j)]      = 0;
      end
    if (bset_en && bset_addr != 5'd0) nb[bset_addr] = 1;
    m_busy = nb;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin m_valid[r] = 0; m_busy[r] = 0; end
  endtask

  task automatic check_comb();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd%0d_byp", p), 64'(rd_b[p*32 +: 32]), 64'(exp_rd(ra[p*5 +: 5], 1)));
      chk($sformatf("rd%0d_nb", p),  64'(rd_n[p*32 +: 32]), 64'(exp_rd(ra[p*5 +: 5], 0)));
      chk($sformatf("bz%0d_byp", p), 64'(rdb_b[p]), 64'(exp_bz(ra[p*5 +: 5], 1)));
      chk($sformatf("bz%0d_nb", p),  64'(rdb_n[p]), 64'(exp_bz(ra[p*5 +: 5], 0)));
    end
  endtask

  task automatic check_cnt();
    chk("cnt_byp", 64'(cnt_b), 64'(exp_cnt()));
    chk("cnt_nb",  64'(cnt_n), 64'(exp_cnt()));
  endtask

  // One cycle: compare combinational outputs, advance model, compare count
  task automatic step();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_cnt();
  endtask

  task automatic idle();
    wen = '0; wa = '0; wd = '0; bset_en = 0; bset_addr = '0;
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      check_comb();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_data[r] = '0;
    model_reset();
    rst_n = 0; ra = '0;
    idle();

    tv[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 0, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0, 6'd0};
    tv[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 6'd0};
    tv[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 0, 5'd0, 5'd7, 32'h22, 32'h0, 0, 0, 6'd0};
    tv[3]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0, 0, 5'd0, 5'd7, 32'h22, 32'h22, 0, 0, 6'd0};
    tv[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 5'd3, 32'h0, 32'h0, 0, 0, 6'd1};
    tv[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd3, 32'h0, 32'h0, 1, 1, 6'd1};
    tv[6]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h33, 0, 5'd0, 5'd3, 32'h33, 32'h0, 0, 1, 6'd0};
    tv[7]  = '{2'b01, 5'd3, 5'd0, 32'h44, 32'h0, 1, 5'd3, 5'd3, 32'h44, 32'h33, 0, 0, 6'd1};
    tv[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd3, 32'h44, 32'h44, 1, 1, 6'd1};
    tv[9]  = '{2'b10, 5'd0, 5'd0, 32'h0, 32'h55, 1, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 6'd1};
    tv[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 6'd1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_cnt();
    @(negedge clk);
    rst_n = 1;
    sweep_reads();
    check_cnt();

    // Directed table
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) begin
      wen = tv[k].wen; wa = {tv[k].wa1, tv[k].wa0}; wd = {tv[k].wd1, tv[k].wd0};
      bset_en = tv[k].bs; bset_addr = tv[k].ba; ra = {5'd0, tv[k].ra0};
      @(negedge clk);
      chk($sformatf("tv%0d_rd_byp", k), 64'(rd_b[31:0]), 64'(tv[k].e_rd_b));
      chk($sformatf("tv%0d_rd_nb", k),  64'(rd_n[31:0]), 64'(tv[k].e_rd_n));
      chk($sformatf("tv%0d_bz_byp", k), 64'(rdb_b[0]),   64'(tv[k].e_bz_b));
      chk($sformatf("tv%0d_bz_nb", k),  64'(rdb_n[0]),   64'(tv[k].e_bz_n));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tv%0d_cnt_byp", k), 64'(cnt_b), 64'(tv[k].e_cnt));
      chk($sformatf("tv%0d_cnt_nb", k),  64'(cnt_n), 64'(tv[k].e_cnt));
    end

    // Randomized traffic against the reference
    for (int c = 0; c < 300; c++) begin
      wen = 2'($urandom_range(0, 3));
      wa = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) wa[9:5] = wa[4:0];
      wd = {$urandom, $urandom};
      bset_en = ($urandom_range(0, 2) == 0);
      bset_addr = 5'($urandom_range(0, 31));
      ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0) ra[4:0] = wa[4:0];
      if ($urandom_range(0, 2) == 0) ra[9:5] = bset_addr;
      step();
    end

    // Fill x1..x31 with i*3 and mark a few busy
    for (int i = 1; i < 32; i += 2) begin
      wen = (i + 1 < 32) ? 2'b11 : 2'b01;
      wa = {5'(i + 1), 5'(i)};
      wd = {32'((i + 1) * 3), 32'(i * 3)};
      bset_en = 0;
      ra = {5'(i), 5'(i + 1)};
      step();
      wen = 0; wa = 0;
    end
    idle();
    for (int i = 2; i < 8; i++) begin
      bset_en = 1; bset_addr = 5'(i); ra = {5'(i), 5'(i - 1)};
      step();
    end
    idle();
    sweep_reads();
    check_cnt();

    // Mid-cycle reset with pending writes and a busy set that must be dropped
    @(posedge clk); #2;
    wen = 2'b11; wa = {5'd9, 5'd4}; wd = {32'hAAAA, 32'hBBBB};
    bset_en = 1; bset_addr = 5'd9;
    rst_n = 0;
    model_reset();
    #1;
    check_cnt();
    sweep_reads();
    @(posedge clk); #1;
    check_cnt();
    @(negedge clk);
    idle();
    rst_n = 1;
    sweep_reads();
    check_cnt();

    // Single write after reset: only x4 visible
    @(posedge clk); #1;
    wen = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'd9}; ra = {5'd4, 5'd4};
    step();
    idle();
    sweep_reads();
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      chk($sformatf("post_rst_x%0d", a), 64'(rd_b[31:0]), (a == 4) ? 64'd9 : 64'd0);
    end
    check_cnt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_regfile_mp.md
Name: vscale_regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the single-write, dual-read core regfile.
- Adds configurable width/depth/port count, a hardware-zero register option, and same-cycle write-to-read bypass.
- Adds reset-to-zero semantics via per-entry valid bits, so the data array needs no reset, and a per-register busy scoreboard for dual-issue pipelines.
- Sits between decode (reads, busy checks) and writeback (writes) in the vscale core.

Parameters:
- XLEN, 32, data width per register.
- NREGS, 32, number of architectural registers.
- AW, 5, address width; NREGS <= 2**AW.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle writes forwarded to reads and busy checks.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/busy sets.
- CW, 6, busy_cnt width; must be >= clog2(NREGS+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ra  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd  output  NRD*XLEN  read data; combinational.
- rd_busy  output  NRD  scoreboard busy flag for each read address; combinational.
- wen  input  NWR  write enables.
- wa  input  NWR*AW  write addresses.
- wd  input  NWR*XLEN  write data.
- bset_en  input  1  mark register busy (issue of a new producer).
- bset_addr  input  AW  register to mark busy.
- busy_cnt  output  CW  number of busy registers; registered.

Behaviour:
- State:
  - data[NREGS] has no reset.
  - valid[NREGS] and busy[NREGS] clear asynchronously to 0 when rst_n = 0.
  - busy_cnt resets to 0.
- Effective write j: wen[j] & rst_n & (wa_j != 0 | ZERO_REG == 0) & (wa_j < NREGS).
  - On the next rising edge: data[wa_j] <= wd_j, valid <= 1, busy <= 0.
- Multiple effective writes to the same address in one cycle: highest-index port wins for data. All colliding ports still clear busy.
- Busy set: bset_en & (bset_addr != 0 | ZERO_REG == 0) & bset_addr < NREGS sets busy[bset_addr] on the next edge.
  - If a write to the same address occurs in the same cycle, the set wins: busy = 1 and the data is written.
- Read port i, evaluated in priority order:
  1. ZERO_REG & ra_i == 0 -> rd_i = 0.
  2. ra_i >= NREGS -> rd_i = 0.
  3. BYPASS & any effective write to ra_i this cycle -> rd_i = wd of the winning (highest-index) port.
  4. valid[ra_i] -> rd_i = data[ra_i].
  5. Otherwise -> rd_i = 0 (register never written since reset).
- rd_busy_i:
  - 0 for the zero register when ZERO_REG = 1, and 0 for out-of-range addresses.
  - With BYPASS, 0 if an effective write to ra_i occurs this cycle.
  - Otherwise equals busy[ra_i].
- Latency:
  - Without bypass, written data is visible on reads 1 cycle after the write edge.
  - With bypass, written data is visible in the same cycle.
  - busy_cnt reflects the busy vector after each edge (registered population count of the next-state busy vector).
- Reset mid-operation:
  - Asserting rst_n forces rd = 0, rd_busy = 0, busy_cnt = 0 immediately.
  - Writes and busy sets in that cycle are dropped.
  - data contents persist but are hidden by valid = 0.
- No handshake: all writes and sets are accepted unconditionally.
- busy_cnt never exceeds NREGS - ZERO_REG.

Test Plan:
- Reset, then read all addresses on both ports -> rd = 0 and rd_busy = 0 everywhere; busy_cnt = 0.
- Write x5 = 0xDEADBEEF on port 0 with BYPASS = 1 and ra0 = 5 in the same cycle -> rd0 = 0xDEADBEEF that cycle.
  - Same test with BYPASS = 0 -> rd0 = 0 that cycle and 0xDEADBEEF the next.
- Both write ports target x7 (port0 = 0x11, port1 = 0x22) -> x7 reads 0x22; a write to x0 -> x0 still reads 0.
- bset x3 -> rd_busy = 1 for ra = 3, busy_cnt = 1.
  - Later write x3 -> busy clears, busy_cnt = 0.
  - Simultaneous bset x3 and write x3 -> busy stays 1 and data updates.
- Fill x1..x31 with i*3, pulse rst_n low mid-cycle -> all reads 0 asynchronously and busy_cnt = 0.
  - After release, write x4 = 9 -> only x4 reads 9; every other register reads 0.
